// File: rtl/vga_sched_pkg.sv
// Shared types and constants for the VGA plot scheduler: FSM encoding,
// pixel field widths and screen limits of the 320x240 adapter.
package vga_sched_pkg;

    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_BURST  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// Bundle between sprite drawers (master side) and the scheduler (slave side),
// including the registered write port that feeds vga_adapter.
interface vga_plot_scheduler_if
    import vga_sched_pkg::*;
#(
    parameter int NREQ = 4
);
    logic                  frame_tick;
    logic [NREQ-1:0]       req;
    // Pixel handshake: a pixel moves only in a cycle where pix_valid[i] and
    // pix_ready[i] are both high; a drawer holds its pixel steady until then.
    logic [NREQ-1:0]       pix_valid;
    logic [NREQ-1:0]       pix_last;
    logic [X_W*NREQ-1:0]   pix_x;
    logic [Y_W*NREQ-1:0]   pix_y;
    logic [C_W*NREQ-1:0]   pix_colour;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       pix_ready;
    logic                  plot;
    logic [X_W-1:0]        X;
    logic [Y_W-1:0]        Y;
    logic [C_W-1:0]        colour;
    logic                  busy;
    logic                  overrun;
    logic                  abort;

    modport master (
        output frame_tick, req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
        input  grant, pix_ready, plot, X, Y, colour, busy, overrun, abort
    );

    modport slave (
        input  frame_tick, req, pix_valid, pix_last, pix_x, pix_y, pix_colour,
        output grant, pix_ready, plot, X, Y, colour, busy, overrun, abort
    );

endinterface

// File: rtl/vga_plot_scheduler_enc.sv
// Lowest-set-bit encoder: picks the highest-priority pending drawer.
module plot_priority_enc #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_none
);

    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        // Scan downwards so the lowest set index is the one left standing.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx  = IDX_W'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_plot_scheduler.sv
// Frame-paced arbiter sharing the single vga_adapter write port between sprite
// drawers, one full burst per drawer per frame in fixed index order.
module vga_plot_scheduler
    import vga_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_PIX = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    vga_plot_scheduler_if.slave  bus,
    output sched_state_t         o_state
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_PIX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PIX - 1);

    sched_state_t     r_state;
    logic [NREQ-1:0]  r_pending;
    logic [IDX_W-1:0] r_cur;
    logic [CNT_W-1:0] r_pix_cnt;
    logic             r_plot;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [C_W-1:0]   r_colour;
    logic             r_overrun;
    logic             r_abort;

    logic [IDX_W-1:0] w_sel_idx;
    logic             w_none;
    logic [NREQ-1:0]  w_grant;
    logic             w_accept;
    logic             w_last;
    logic             w_burst_end;
    logic [X_W-1:0]   w_px;
    logic [Y_W-1:0]   w_py;
    logic [C_W-1:0]   w_pc;

    plot_priority_enc #(.NREQ(NREQ)) u_enc (
        .i_vec  (r_pending),
        .o_idx  (w_sel_idx),
        .o_none (w_none)
    );

    always_comb begin
        w_grant = '0;
        if (r_state == S_BURST) w_grant[r_cur] = 1'b1;
    end

    assign w_accept    = (r_state == S_BURST) && bus.pix_valid[r_cur];
    assign w_last      = bus.pix_last[r_cur];
    // A burst without a last marker is cut off on its MAX_PIX-th pixel.
    assign w_burst_end = w_accept && (w_last || (r_pix_cnt == CNT_LAST));
    assign w_px        = bus.pix_x[int'(r_cur) * X_W +: X_W];
    assign w_py        = bus.pix_y[int'(r_cur) * Y_W +: Y_W];
    assign w_pc        = bus.pix_colour[int'(r_cur) * C_W +: C_W];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_cur     <= '0;
            r_pix_cnt <= '0;
            r_plot    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_overrun <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            if (bus.frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_tick) begin
                        r_pending <= bus.req;
                        r_state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_none) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cur     <= w_sel_idx;
                        r_pix_cnt <= '0;
                        r_state   <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_accept) begin
                        r_plot    <= 1'b1;
                        r_x       <= w_px;
                        r_y       <= w_py;
                        r_colour  <= w_pc;
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                    if (w_burst_end) begin
                        if (!w_last) r_abort <= 1'b1;
                        r_pending[r_cur] <= 1'b0;
                        r_state          <= S_SELECT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant     = w_grant;
    assign bus.pix_ready = w_grant;
    assign bus.plot      = r_plot;
    assign bus.X         = r_x;
    assign bus.Y         = r_y;
    assign bus.colour    = r_colour;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.overrun   = r_overrun;
    assign bus.abort     = r_abort;
    assign o_state       = r_state;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Directed bench for vga_plot_scheduler: per-scenario cycle tables plus a
// pixel scoreboard fed by the requester source queues.
module tb_vga_plot_scheduler;
    import vga_sched_pkg::*;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       last;
        logic [3:0] gap;
    } pix_t;

    logic         clk;
    logic         resetn;
    sched_state_t dbg_state;

    int checks   = 0;
    int errors   = 0;
    int plot_cnt = 0;

    pix_t        src_q [4][$];
    logic [19:0] exp_q [$];

    vga_plot_scheduler_if #(.NREQ(4)) bus ();

    vga_plot_scheduler #(.NREQ(4), .MAX_PIX(8)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester model: each source presents its queue head, honouring gaps.
    initial begin : src_driver
        logic [3:0] acc;
        pix_t hd;
        bus.pix_valid  = '0;
        bus.pix_last   = '0;
        bus.pix_x      = '0;
        bus.pix_y      = '0;
        bus.pix_colour = '0;
        forever begin
            @(negedge clk);
            acc = bus.pix_valid & bus.pix_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
                bus.pix_valid[i] = 1'b0;
                bus.pix_last[i]  = 1'b0;
                if (src_q[i].size() > 0) begin
                    hd = src_q[i][0];
                    if (hd.gap != 4'd0) begin
                        hd.gap = hd.gap - 4'd1;
                        src_q[i][0] = hd;
                    end else begin
                        bus.pix_valid[i]          = 1'b1;
                        bus.pix_last[i]           = hd.last;
                        bus.pix_x[i*9 +: 9]       = hd.x;
                        bus.pix_y[i*8 +: 8]       = hd.y;
                        bus.pix_colour[i*3 +: 3]  = hd.c;
                    end
                end
            end
        end
    end

    // Scoreboard: every plot must match the next expected pixel.
    always @(negedge clk) begin
        if (bus.plot === 1'b1) begin
            plot_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, expected no plot",
                         bus.X, bus.Y, bus.colour);
            end else if ({bus.X, bus.Y, bus.colour} !== exp_q[0]) begin
                errors++;
                $display("FAIL plot_pixel: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
                         bus.X, bus.Y, bus.colour, exp_q[0][19:11], exp_q[0][10:3], exp_q[0][2:0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic push_pix(input int r, input int x, input int y, input int c,
                            input bit last, input int gap, input bit exp_plot);
        pix_t p;
        p.x    = 9'(x);
        p.y    = 8'(y);
        p.c    = 3'(c);
        p.last = last;
        p.gap  = 4'(gap);
        src_q[r].push_back(p);
        if (exp_plot) exp_q.push_back({p.x, p.y, p.c});
    endtask

    // Returns one cycle after the edge that samples the tick (SELECT cycle).
    task automatic do_tick;
        @(posedge clk);
        #1 bus.frame_tick = 1'b1;
        @(posedge clk);
        #1 bus.frame_tick = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
        checks++; if (bus.grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant); end
        checks++; if (bus.pix_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.pix_ready); end
        checks++; if ({bus.plot, bus.busy, bus.overrun, bus.abort} !== 4'b0) begin errors++; $display("FAIL reset_flags: got plot/busy/ovr/abt=%b expected 0000", {bus.plot, bus.busy, bus.overrun, bus.abort}); end
        checks++; if ({bus.X, bus.Y, bus.colour} !== 20'd0) begin errors++; $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d expected 0", bus.X, bus.Y, bus.colour); end
        resetn = 1'b1;
    endtask

    task automatic test_empty_frame;
        @(negedge clk);
        bus.req = 4'b0000;
        do_tick;
        @(negedge clk);
        checks++; if (dbg_state !== S_SELECT || bus.busy !== 1'b1) begin errors++; $display("FAIL empty_select: got state=%0d busy=%b expected state=%0d busy=1", dbg_state, bus.busy, S_SELECT); end
        @(negedge clk);
        checks++; if (dbg_state !== S_IDLE || bus.busy !== 1'b0) begin errors++; $display("FAIL empty_idle: got state=%0d busy=%b expected state=%0d busy=0", dbg_state, bus.busy, S_IDLE); end
        checks++; if (bus.grant !== 4'b0 || bus.plot !== 1'b0) begin errors++; $display("FAIL empty_quiet: got grant=%b plot=%b expected 0000/0", bus.grant, bus.plot); end
    endtask

    task automatic test_basic_frame;
        logic [3:0] g_tab [9];
        logic       p_tab [9];
        g_tab = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
        p_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 3; k++) push_pix(0, 10 + k, 220, 7, k == 2, 0, 1'b1);
        push_pix(2, 100, 50, 3, 1'b0, 0, 1'b1);
        push_pix(2, 101, 50, 3, 1'b1, 0, 1'b1);
        bus.req = 4'b0101;
        do_tick;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++; if (bus.grant !== g_tab[c-1]) begin errors++; $display("FAIL basic_grant c=%0d: got %b expected %b", c, bus.grant, g_tab[c-1]); end
            checks++; if (bus.plot !== p_tab[c-1]) begin errors++; $display("FAIL basic_plot c=%0d: got %b expected %b", c, bus.plot, p_tab[c-1]); end
            checks++; if (bus.busy !== 1'(c != 9)) begin errors++; $display("FAIL basic_busy c=%0d: got %b expected %b", c, bus.busy, c != 9); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d pixels outstanding expected 0", exp_q.size()); end
        bus.req = 4'b0000;
    endtask

    task automatic test_stall;
        logic [3:0] g_tab [9];
        logic       p_tab [9];
        g_tab = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
        p_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        push_pix(1, 30, 40, 1, 1'b0, 0, 1'b1);
        push_pix(1, 31, 41, 2, 1'b0, 0, 1'b1);
        push_pix(1, 32, 42, 3, 1'b0, 2, 1'b1);
        push_pix(1, 33, 43, 4, 1'b1, 0, 1'b1);
        bus.req = 4'b0010;
        do_tick;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++; if (bus.pix_ready !== g_tab[c-1]) begin errors++; $display("FAIL stall_ready c=%0d: got %b expected %b", c, bus.pix_ready, g_tab[c-1]); end
            checks++; if (bus.plot !== p_tab[c-1]) begin errors++; $display("FAIL stall_plot c=%0d: got %b expected %b", c, bus.plot, p_tab[c-1]); end
            if (c == 5 || c == 6) begin
                checks++; if ({bus.X, bus.Y} !== {9'd31, 8'd41}) begin errors++; $display("FAIL stall_hold c=%0d: got x=%0d y=%0d expected x=31 y=41", c, bus.X, bus.Y); end
            end
        end
        checks++; if (bus.busy !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL stall_end: got busy=%b outstanding=%0d expected 0/0", bus.busy, exp_q.size()); end
        bus.req = 4'b0000;
    endtask

    task automatic test_late_request;
        logic [3:0] g_tab [5];
        g_tab = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        @(negedge clk);
        push_pix(0, 0, 0, 1, 1'b1, 0, 1'b1);
        bus.req = 4'b0001;
        do_tick;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (bus.grant !== g_tab[c-1]) begin errors++; $display("FAIL late_grant c=%0d: got %b expected %b", c, bus.grant, g_tab[c-1]); end
            if (c == 1) begin
                bus.req = 4'b1001;
                push_pix(3, SCREEN_W - 1, SCREEN_H - 1, 6, 1'b1, 0, 1'b1);
            end
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL late_idle: got busy=%b expected 0", bus.busy); end
        bus.req = 4'b1000;
        do_tick;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.grant !== 4'b1000) begin errors++; $display("FAIL late_served: got %b expected 1000", bus.grant); end
        @(negedge clk);
        checks++; if (bus.plot !== 1'b1) begin errors++; $display("FAIL late_plot: got %b expected 1", bus.plot); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL late_end: got busy=%b outstanding=%0d expected 0/0", bus.busy, exp_q.size()); end
        bus.req = 4'b0000;
    endtask

    task automatic test_overrun;
        logic [3:0] g_tab [8];
        g_tab = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        @(negedge clk);
        for (int k = 0; k < 4; k++) push_pix(0, 50 + k, 100, 4, k == 3, 0, 1'b1);
        bus.req = 4'b0001;
        do_tick;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (bus.grant !== g_tab[c-1]) begin errors++; $display("FAIL ovr_grant c=%0d: got %b expected %b", c, bus.grant, g_tab[c-1]); end
            checks++; if (bus.busy !== 1'(c <= 6)) begin errors++; $display("FAIL ovr_busy c=%0d: got %b expected %b", c, bus.busy, c <= 6); end
            checks++; if (bus.overrun !== 1'(c >= 3)) begin errors++; $display("FAIL ovr_flag c=%0d: got %b expected %b", c, bus.overrun, c >= 3); end
            if (c == 2) begin
                bus.frame_tick = 1'b1;
                bus.req        = 4'b0110;
            end
            if (c == 3) bus.frame_tick = 1'b0;
        end
        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        checks++; if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL ovr_sticky: got overrun=%b busy=%b expected 1/0", bus.overrun, bus.busy); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_drain: got %0d outstanding expected 0", exp_q.size()); end
    endtask

    task automatic test_abort;
        logic [3:0] g_tab [13];
        logic       p_tab [13];
        int         plots_before;
        g_tab = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h0};
        p_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) push_pix(0, 200 + k, 5, 2, 1'b0, 0, k < 8);
        push_pix(1, SCREEN_W - 1, SCREEN_H - 1, 5, 1'b1, 0, 1'b1);
        bus.req = 4'b0011;
        plots_before = plot_cnt;
        do_tick;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            checks++; if (bus.grant !== g_tab[c-1]) begin errors++; $display("FAIL abort_grant c=%0d: got %b expected %b", c, bus.grant, g_tab[c-1]); end
            checks++; if (bus.plot !== p_tab[c-1]) begin errors++; $display("FAIL abort_plot c=%0d: got %b expected %b", c, bus.plot, p_tab[c-1]); end
            checks++; if (bus.abort !== 1'(c >= 10)) begin errors++; $display("FAIL abort_flag c=%0d: got %b expected %b", c, bus.abort, c >= 10); end
        end
        checks++; if (plot_cnt - plots_before != 9) begin errors++; $display("FAIL abort_count: got %0d plots expected 9", plot_cnt - plots_before); end
        checks++; if (bus.busy !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL abort_end: got busy=%b outstanding=%0d expected 0/0", bus.busy, exp_q.size()); end
        src_q[0].delete();
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst;
        logic [3:0] g_tab [5];
        g_tab = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
        @(negedge clk);
        for (int k = 0; k < 5; k++) push_pix(0, 150 + k, 60, 5, k == 4, 0, k == 0);
        bus.req = 4'b0001;
        do_tick;
        repeat (3) @(negedge clk);
        checks++; if (bus.plot !== 1'b1 || bus.X !== 9'd150) begin errors++; $display("FAIL rst_pre: got plot=%b x=%0d expected 1/150", bus.plot, bus.X); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (dbg_state !== S_IDLE || bus.grant !== 4'b0 || bus.pix_ready !== 4'b0) begin errors++; $display("FAIL rst_state: got state=%0d grant=%b ready=%b expected %0d/0000/0000", dbg_state, bus.grant, bus.pix_ready, S_IDLE); end
        checks++; if ({bus.plot, bus.busy, bus.overrun, bus.abort} !== 4'b0) begin errors++; $display("FAIL rst_flags: got plot/busy/ovr/abt=%b expected 0000", {bus.plot, bus.busy, bus.overrun, bus.abort}); end
        checks++; if ({bus.X, bus.Y, bus.colour} !== 20'd0) begin errors++; $display("FAIL rst_pixel: got x=%0d y=%0d c=%0d expected 0", bus.X, bus.Y, bus.colour); end
        resetn = 1'b1;
        @(negedge clk);
        src_q[0].delete();
        push_pix(0, 160, 61, 2, 1'b0, 0, 1'b1);
        push_pix(0, 161, 61, 2, 1'b1, 0, 1'b1);
        do_tick;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (bus.grant !== g_tab[c-1]) begin errors++; $display("FAIL rst_restart_grant c=%0d: got %b expected %b", c, bus.grant, g_tab[c-1]); end
            checks++; if (bus.busy !== 1'(c != 5)) begin errors++; $display("FAIL rst_restart_busy c=%0d: got %b expected %b", c, bus.busy, c != 5); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_drain: got %0d outstanding expected 0", exp_q.size()); end
        bus.req = 4'b0000;
    endtask

    initial begin
        resetn         = 1'b0;
        bus.frame_tick = 1'b0;
        bus.req        = 4'b0000;
        test_reset;
        test_empty_frame;
        test_basic_frame;
        test_stall;
        test_late_request;
        test_overrun;
        test_abort;
        test_reset_mid_burst;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
